// File: rtl/ct_f_spsram_ctrl_pkg.sv
// Shared types and defaults for the 2048x128 single-port SRAM controller.
// Holds the controller state encoding and the default array geometry.
package ct_f_spsram_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 11;
    localparam int DEF_DATA_WIDTH = 128;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/ct_f_spsram_rsp_fifo.sv
// Two-entry read-response FIFO for the SRAM controller.
// Overflow is prevented upstream by the request credit check.
module ct_f_spsram_rsp_fifo
    import ct_f_spsram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [1:0]            cnt
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;

    assign dout = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/ct_f_spsram_2048x128_ctrl.sv
// Request/response front end for a 2048x128 single-port SRAM macro,
// with optional zero-fill after reset and a credit-guarded read path.
module ct_f_spsram_2048x128_ctrl
    import ct_f_spsram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int INIT_EN    = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    state_e                state;
    state_e                state_nxt;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  rd_inflight;
    logic [1:0]            fifo_cnt;
    logic                  pop;
    logic                  acc;
    logic [2:0]            pending;

    // Reads already committed: queued plus the one still in the macro.
    assign pending = {1'b0, fifo_cnt} + {2'b00, rd_inflight}
                   - {2'b00, pop};

    assign rsp_vld = !RST && (fifo_cnt != 2'd0);
    assign pop     = rsp_vld && rsp_rdy;
    assign req_rdy = !RST && (state == ST_RUN)
                   && (req_wr || (pending < 3'd2));
    assign acc     = req_vld && req_rdy;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
            init_cnt    <= '0;
            init_done   <= 1'b0;
            rd_inflight <= 1'b0;
        end else begin
            state       <= state_nxt;
            init_done   <= (state_nxt == ST_RUN);
            rd_inflight <= acc && !req_wr;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;
        if (!RST) begin
            unique case (state)
                ST_INIT: begin
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_wen  = '0;
                    sram_a    = init_cnt;
                    if (init_cnt == '1) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (acc) begin
                        sram_cen = 1'b0;
                        sram_a   = req_addr;
                        if (req_wr) begin
                            sram_gwen = 1'b0;
                            sram_wen  = '0;
                            sram_d    = req_wdata;
                        end
                    end
                end
            endcase
        end
    end

    ct_f_spsram_rsp_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_rsp_fifo (
        .CLK  (CLK),
        .RST  (RST),
        .push (rd_inflight),
        .pop  (pop),
        .din  (sram_q),
        .dout (rsp_data),
        .cnt  (fifo_cnt)
    );

endmodule

// File: doc/ct_f_spsram_2048x128_ctrl.md
CT_F_SPSRAM_2048X128_CTRL -- requirements
Module: ct_f_spsram_2048x128_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, meaning the SRAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 128, meaning the SRAM word width.
REQ-003 SHALL have parameter INIT_EN, default 1, meaning the SRAM is zero-filled after reset.
REQ-004 SHALL use one clock and a synchronous, active-high reset:
- CLK  in  1  clock; all state updates on its rising edge
- RST  in  1  synchronous, active-high reset
REQ-005 SHALL have the following request ports:
- req_vld  in  1  request valid
- req_rdy  out  1  request accepted when req_vld and req_rdy are both high
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
REQ-006 SHALL have the following response and status ports:
- rsp_vld  out  1  read data valid
- rsp_rdy  in  1  consumer ready
- rsp_data  out  DATA_WIDTH  read data
- init_done  out  1  zero-fill complete
REQ-007 SHALL have the following SRAM ports:
- sram_a  out  ADDR_WIDTH  address
- sram_cen  out  1  chip enable, active-low
- sram_gwen  out  1  global write enable, active-low
- sram_wen  out  DATA_WIDTH  bit write enables, active-low
- sram_d  out  DATA_WIDTH  write data
- sram_q  in  DATA_WIDTH  read data, valid one cycle after the read is issued

Function
REQ-008 SHALL implement states INIT and RUN.
- RST enters INIT when INIT_EN=1, otherwise RUN.
REQ-009 In INIT, SHALL write zeros to address init_cnt each cycle:
- sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_d=0.
- init_cnt counts 0..2^ADDR_WIDTH-1.
- After the write at the last address, the block moves to RUN on the next cycle (2048 INIT cycles).
REQ-010 init_done SHALL be a registered flag that is 1 exactly while the block is in RUN.
REQ-011 req_rdy SHALL be 0 in INIT.
- In RUN: req_rdy = req_wr OR (fifo_cnt + rd_inflight - pop < 2), where pop = rsp_vld AND rsp_rdy.
REQ-012 On an accepted request, SHALL drive the SRAM combinationally in the same cycle:
- sram_cen=0, sram_a=req_addr.
- Write: sram_gwen=0, sram_wen=all 0, sram_d=req_wdata.
- Read: sram_gwen=1, sram_wen=all 1.
REQ-013 In RUN with no accepted request, SHALL drive sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0.
REQ-014 A read accepted in cycle N SHALL set rd_inflight during cycle N+1.
- sram_q is pushed into the response FIFO at the end of cycle N+1.
- rsp_vld is asserted no earlier than cycle N+2.
REQ-015 Response FIFO: 2 entries.
- rsp_data = FIFO head; rsp_vld = (fifo_cnt != 0).
- Push and pop in the same cycle leave fifo_cnt unchanged.
- Overflow SHALL be impossible, guaranteed by the REQ-011 credit rule.
REQ-016 Responses SHALL return in read-issue order; writes produce no response.
REQ-017 A read accepted in the cycle after a write to the same address SHALL return the newly written data.
REQ-018 With rsp_rdy held at 1, SHALL sustain one read per cycle.
REQ-019 rsp_data and rsp_vld SHALL remain stable while rsp_vld=1 and rsp_rdy=0.

Reset
REQ-020 RST SHALL, on the next rising CLK edge:
- clear fifo_cnt, rd_inflight, init_cnt and init_done;
- drop FIFO contents and any in-flight read;
- enter the REQ-008 state.
REQ-021 During reset and in the cycle it is applied, outputs SHALL be: req_rdy=0, rsp_vld=0, sram_cen=1, sram_gwen=1, sram_wen=all 1.
REQ-022 RST asserted mid-INIT or mid-RUN SHALL restart INIT from address 0; no stale response is ever presented.

Structure
REQ-023 SHALL place the state encoding (INIT, RUN) and the default ADDR_WIDTH/DATA_WIDTH constants in a shared package, ct_f_spsram_ctrl_pkg.
REQ-024 SHALL instantiate the 2-entry response FIFO as one sub-module, ct_f_spsram_rsp_fifo.
- Interface: push, pop, din, dout, cnt.
- Uses the same CLK/RST.

Verification
REQ-025 Reset, then idle: init_done rises after exactly 2048 INIT cycles; a read of addr 0x7FF returns 0.
REQ-026 Write 0xA5..A5 to 0x123, then read 0x123 in the next cycle: rsp_data=0xA5..A5, two cycles after the read is accepted.
REQ-027 Back-to-back reads of 0x001..0x010 with rsp_rdy=1: 16 responses in order, no req_rdy drop, no gaps.
REQ-028 rsp_rdy=0 while issuing reads: req_rdy for reads drops after 2 reads, while writes are still accepted; releasing rsp_rdy drains the FIFO in order.
REQ-029 RST asserted with 1 read in flight and 2 FIFO entries: rsp_vld=0 on the next cycle, INIT restarts at address 0, and no old data ever appears.
REQ-030 INIT_EN=0: init_done=1 one cycle after reset release, and a request is accepted immediately.
